// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with stall, redirect, stop/drain/halt and perf counters
module pc_sequencer #(
    parameter int unsigned         ADDR_W     = 32,
    parameter int unsigned         CNT_W      = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter int unsigned         PC_STEP    = 1,
    parameter int unsigned         HALT_DELAY = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              stall,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic [1:0]        pc_inc,
    output logic [ADDR_W-1:0] current_pc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  redirect_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic              draining,
    output logic              halt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    // Last drain-counter value before halting; unused when HALT_DELAY is zero.
    localparam logic [7:0]        DRAIN_LAST = (HALT_DELAY == 0) ? 8'd0 : 8'(HALT_DELAY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [7:0]        r_drain_cnt;
    logic [7:0]        w_drain_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_redirect_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_redirect_inc;
    logic              w_stall_inc;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drain_nxt    = r_drain_cnt;
        w_redirect_inc = 1'b0;
        w_stall_inc    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (stall) begin
                    w_stall_inc = 1'b1;
                end else begin
                    case (pc_inc)
                        2'b00: w_pc_nxt = r_pc + STEP;
                        2'b01, 2'b10: begin
                            w_pc_nxt       = next_pc;
                            w_redirect_inc = 1'b1;
                        end
                        default: begin
                            w_pc_nxt    = next_pc;
                            w_drain_nxt = 8'd0;
                            w_state_nxt = (HALT_DELAY == 0) ? S_HALTED : S_DRAIN;
                        end
                    endcase
                end
            end
            S_DRAIN: begin
                w_drain_nxt = r_drain_cnt + 8'd1;
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            r_state        <= S_RUN;
            r_pc           <= RESET_PC;
            r_drain_cnt    <= 8'd0;
            r_cycle_cnt    <= CNT_W'(1);
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drain_cnt <= w_drain_nxt;
            // Counters saturate rather than wrap so long runs stay readable.
            if (r_state != S_HALTED && r_cycle_cnt != CNT_MAX) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_redirect_inc && r_redirect_cnt != CNT_MAX) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            if (w_stall_inc && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign current_pc     = r_pc;
    assign cycle_count    = r_cycle_cnt;
    assign redirect_count = r_redirect_cnt;
    assign stall_count    = r_stall_cnt;
    assign draining       = (r_state == S_DRAIN);
    assign halt           = (r_state == S_HALTED);

endmodule
